// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC, debug-loadable word instruction memory, IF/ID register, IDLE/RUN/DONE control.
// Latency 1 cycle PC->IF/ID; i_halt freezes everything, i_stall holds PC and IF/ID; macro IF_BRANCH_DELAY_SLOT_EN.
module instruction_fetch #(
    parameter int          IMEM_DEPTH  = 256,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_stall,
    input  logic        i_halt,
    input  logic        i_jump,
    input  logic [31:0] i_jump_address,
    input  logic        i_load_enable,
    input  logic [31:0] i_load_addr,
    input  logic [31:0] i_load_data,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_current,
    output logic        o_done
);
    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] imem [IMEM_DEPTH];

    logic [AW-1:0] fetch_idx;
    logic [31:0]   fetch_word;
    logic [31:0]   pc_plus4;
    logic          pc_in_range;
    logic          fetch_halt;
    logic          load_ok;
    logic          unused;

    assign fetch_idx    = pc[AW+1:2];
    assign fetch_word   = imem[fetch_idx];
    assign pc_plus4     = pc + 32'd4;
    assign pc_in_range  = (pc[31:AW+2] == '0);
    assign fetch_halt   = (fetch_word[31:26] == HALT_OPCODE);
    assign load_ok      = i_load_enable && !i_halt && (state != RUN)
                          && (i_load_addr[31:AW+2] == '0);
    assign o_pc_current = pc;
    assign unused       = ^{i_load_addr[1:0], i_jump_address[1:0]};

    // Memory has no reset so a program survives an aborted run.
    always_ff @(posedge i_clk) begin
        if (load_ok)
            imem[i_load_addr[AW+1:2]] <= i_load_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            pc            <= '0;
            o_instruction <= '0;
            o_pc          <= '0;
            o_done        <= 1'b0;
        end else if (!i_halt) begin
            case (state)
                IDLE, DONE: begin
                    o_instruction <= '0;
                    o_pc          <= '0;
                    if (i_start) begin
                        state  <= RUN;
                        pc     <= '0;
                        o_done <= 1'b0;
                    end
                end
                RUN: begin
                    if (i_stall) begin
                        // ID re-presents any jump once the stall clears
                    end else if (i_jump) begin
                        pc <= {i_jump_address[31:2], 2'b00};
`ifdef IF_BRANCH_DELAY_SLOT_EN
                        o_instruction <= fetch_word;
                        o_pc          <= pc_plus4;
`else
                        o_instruction <= '0;
                        o_pc          <= '0;
`endif
                    end else if (!pc_in_range || fetch_halt) begin
                        o_instruction <= '0;
                        o_pc          <= '0;
                        state         <= DONE;
                        o_done        <= 1'b1;
                    end else begin
                        o_instruction <= fetch_word;
                        o_pc          <= pc_plus4;
                        pc            <= pc_plus4;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded directed bench for instruction_fetch: stimulus queues expected IF/ID state, a monitor compares.
module tb_instruction_fetch;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_halt = 1'b0;
    logic        i_jump = 1'b0;
    logic [31:0] i_jump_address = '0;
    logic        i_load_enable = 1'b0;
    logic [31:0] i_load_addr = '0;
    logic [31:0] i_load_data = '0;
    logic [31:0] o_instruction, o_pc, o_pc_current;
    logic        o_done;

    instruction_fetch dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_stall(i_stall),
        .i_halt(i_halt), .i_jump(i_jump), .i_jump_address(i_jump_address),
        .i_load_enable(i_load_enable), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
        .o_instruction(o_instruction), .o_pc(o_pc), .o_pc_current(o_pc_current), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcc;
        logic        done;
    } exp_t;

    localparam logic [31:0] W0   = 32'h2001_0001;
    localparam logic [31:0] W1   = 32'h2002_0002;
    localparam logic [31:0] W2   = 32'h2003_0003;
    localparam logic [31:0] HALT = 32'hFC00_0000;
    localparam logic [31:0] W16  = 32'h2010_0010;
    localparam logic [31:0] W17  = 32'h2011_0011;
    localparam logic [31:0] WNEW = 32'h2000_0AAA;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic exp_t mk(logic [31:0] instr, logic [31:0] pc, logic [31:0] pcc, logic done);
        exp_t e;
        e.instr = instr; e.pc = pc; e.pcc = pcc; e.done = done;
        return e;
    endfunction

    function automatic logic [31:0] fill(int i);
        return 32'h2000_0000 | i;
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle at most, checked just after the edge it describes.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("instruction", o_instruction, e.instr);
                cmp("pc", o_pc, e.pc);
                cmp("pc_current", o_pc_current, e.pcc);
                cmp("done", {31'd0, o_done}, {31'd0, e.done});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    // Queue the state expected after the next edge, then release single-cycle inputs.
    task automatic tick(exp_t e);
        q.push_back(e);
        @(posedge i_clk);
        #2;
        i_start = 0; i_stall = 0; i_halt = 0; i_jump = 0;
        i_load_enable = 0; i_jump_address = '0;
    endtask

    task automatic load(logic [31:0] addr, logic [31:0] data, exp_t e);
        i_load_enable = 1; i_load_addr = addr; i_load_data = data;
        tick(e);
    endtask

    initial begin
        // Reset held
        tick(mk(0, 0, 0, 0));
        tick(mk(0, 0, 0, 0));
        i_reset = 0;

        // Program: ADDI x3, HALT; jump targets at 16,17 then HALT at 18
        load(32'h00, W0,   mk(0, 0, 0, 0));
        load(32'h04, W1,   mk(0, 0, 0, 0));
        load(32'h08, W2,   mk(0, 0, 0, 0));
        load(32'h0C, HALT, mk(0, 0, 0, 0));
        load(32'h40, W16,  mk(0, 0, 0, 0));
        load(32'h44, W17,  mk(0, 0, 0, 0));
        load(32'h48, HALT, mk(0, 0, 0, 0));

        // Basic run to HALT
        i_start = 1; tick(mk(0, 0, 0, 0));
        tick(mk(W0, 4, 4, 0));
        tick(mk(W1, 8, 8, 0));
        tick(mk(W2, 12, 12, 0));
        tick(mk(0, 0, 12, 1));
        i_start = 1; i_halt = 1; tick(mk(0, 0, 12, 1));

        // Stall at PC=8, then halt freeze with a jump pending
        i_start = 1; tick(mk(0, 0, 0, 0));
        tick(mk(W0, 4, 4, 0));
        tick(mk(W1, 8, 8, 0));
        i_stall = 1; tick(mk(W1, 8, 8, 0));
        i_stall = 1; tick(mk(W1, 8, 8, 0));
        i_halt = 1; i_jump = 1; i_jump_address = 32'h40; tick(mk(W1, 8, 8, 0));
        tick(mk(W2, 12, 12, 0));
        tick(mk(0, 0, 12, 1));

        // Jump at PC=8 to 0x43
        i_start = 1; tick(mk(0, 0, 0, 0));
        tick(mk(W0, 4, 4, 0));
        tick(mk(W1, 8, 8, 0));
        i_jump = 1; i_jump_address = 32'h43;
`ifdef IF_BRANCH_DELAY_SLOT_EN
        tick(mk(W2, 12, 32'h40, 0));
`else
        tick(mk(0, 0, 32'h40, 0));
`endif
        tick(mk(W16, 32'h44, 32'h44, 0));
        tick(mk(W17, 32'h48, 32'h48, 0));
        tick(mk(0, 0, 32'h48, 1));

        // Jump together with stall is dropped; re-asserted jump is taken
        i_start = 1; tick(mk(0, 0, 0, 0));
        tick(mk(W0, 4, 4, 0));
        tick(mk(W1, 8, 8, 0));
        i_stall = 1; i_jump = 1; i_jump_address = 32'h40; tick(mk(W1, 8, 8, 0));
        i_jump = 1; i_jump_address = 32'h40;
`ifdef IF_BRANCH_DELAY_SLOT_EN
        tick(mk(W2, 12, 32'h40, 0));
`else
        tick(mk(0, 0, 32'h40, 0));
`endif
        tick(mk(W16, 32'h44, 32'h44, 0));
        tick(mk(W17, 32'h48, 32'h48, 0));
        tick(mk(0, 0, 32'h48, 1));

        // Fill whole memory without HALT; low address bits must be ignored
        for (int i = 0; i < 256; i++)
            load(32'(i * 4 + (i % 4)), fill(i), mk(0, 0, 32'h48, 1));
        // Out-of-range load aliasing word 5 must be ignored
        load(32'h0000_0414, HALT, mk(0, 0, 32'h48, 1));

        // Run off the end; a load during RUN must not land
        i_start = 1; tick(mk(0, 0, 0, 0));
        for (int i = 0; i < 256; i++) begin
            if (i == 2) begin
                i_load_enable = 1; i_load_addr = 32'h14; i_load_data = HALT;
            end
            tick(mk(fill(i), 32'(i * 4 + 4), 32'(i * 4 + 4), 0));
        end
        tick(mk(0, 0, 32'd1024, 1));

        // Load and start on the same edge, then asynchronous reset mid-run
        i_start = 1; i_load_enable = 1; i_load_addr = 32'h0; i_load_data = WNEW;
        tick(mk(0, 0, 0, 0));
        tick(mk(WNEW, 4, 4, 0));
        tick(mk(fill(1), 8, 8, 0));
        i_reset = 1;
        #1;
        cmp("async_rst_instruction", o_instruction, 32'h0);
        cmp("async_rst_pc", o_pc, 32'h0);
        cmp("async_rst_pc_current", o_pc_current, 32'h0);
        cmp("async_rst_done", {31'd0, o_done}, 32'h0);
        tick(mk(0, 0, 0, 0));
        i_reset = 0;
        i_start = 1; tick(mk(0, 0, 0, 0));
        tick(mk(WNEW, 4, 4, 0));
        tick(mk(fill(1), 8, 8, 0));

        @(posedge i_clk);
        #2;
        cmp("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
